// File: rtl/hdmi_video_timing.sv
// Raster timing generator: free-running x/y counters with registered sync, display enable and
// line/frame strobes. Sync/active can be delayed to line up with a pipelined pixel path.
module hdmi_video_timing #(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned H_FRONT    = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BACK     = 48,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_FRONT    = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BACK     = 33,
  parameter bit          HSYNC_POL  = 1'b0,
  parameter bit          VSYNC_POL  = 1'b0,
  parameter int unsigned X_WIDTH    = 10,
  parameter int unsigned Y_WIDTH    = 10,
  parameter int unsigned SYNC_DELAY = 0
) (
  input  logic               clk_pixel,
  input  logic               resetn,
  output logic [X_WIDTH-1:0] x,
  output logic [Y_WIDTH-1:0] y,
  output logic               hsync,
  output logic               vsync,
  output logic               active,
  output logic               line_start,
  output logic               frame_start
);

  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned HS_START = H_ACTIVE + H_FRONT;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FRONT;
  localparam int unsigned VS_END   = VS_START + V_SYNC;

  localparam logic [X_WIDTH-1:0] X_LAST = X_WIDTH'(H_TOTAL - 1);
  localparam logic [Y_WIDTH-1:0] Y_LAST = Y_WIDTH'(V_TOTAL - 1);

  // First synchroniser stage for reset release; the counter and flag registers, which only
  // load new values once run_q is high, form the second stage.
  logic run_q;

  always_ff @(posedge clk_pixel or negedge resetn) begin
    if (!resetn) begin
      run_q <= 1'b0;
    end else begin
      run_q <= 1'b1;
    end
  end

  logic [X_WIDTH-1:0] x_q, x_d;
  logic [Y_WIDTH-1:0] y_q, y_d;
  logic               x_wrap;
  logic               act_d, hs_d, vs_d, ls_d, fs_d;

  // Flags are decoded from the next-state counters so they line up with x/y when registered.
  always_comb begin
    x_wrap = (x_q == X_LAST);
    x_d    = x_q;
    y_d    = y_q;
    if (run_q) begin
      x_d = x_wrap ? '0 : x_q + 1'b1;
      if (x_wrap) begin
        y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
      end
    end
    act_d = (32'(x_d) < H_ACTIVE) && (32'(y_d) < V_ACTIVE);
    hs_d  = (32'(x_d) >= HS_START) && (32'(x_d) < HS_END);
    vs_d  = (32'(y_d) >= VS_START) && (32'(y_d) < VS_END);
    ls_d  = (x_d == '0);
    fs_d  = ls_d && (y_d == '0);
  end

  logic [2:0] flg_q;  // {vs, hs, act}, asserted-high
  logic       ls_q, fs_q;

  always_ff @(posedge clk_pixel or negedge resetn) begin
    if (!resetn) begin
      x_q   <= X_LAST;
      y_q   <= Y_LAST;
      flg_q <= '0;
      ls_q  <= 1'b0;
      fs_q  <= 1'b0;
    end else begin
      x_q   <= x_d;
      y_q   <= y_d;
      flg_q <= {vs_d, hs_d, act_d};
      ls_q  <= ls_d;
      fs_q  <= fs_d;
    end
  end

  logic [2:0] flg_out;

  if (SYNC_DELAY == 0) begin : g_nodly
    assign flg_out = flg_q;
  end else begin : g_dly
    logic [2:0] dly_q [SYNC_DELAY];

    always_ff @(posedge clk_pixel or negedge resetn) begin
      if (!resetn) begin
        for (int unsigned i = 0; i < SYNC_DELAY; i++) begin
          dly_q[i] <= '0;
        end
      end else begin
        dly_q[0] <= flg_q;
        for (int unsigned i = 1; i < SYNC_DELAY; i++) begin
          dly_q[i] <= dly_q[i-1];
        end
      end
    end

    assign flg_out = dly_q[SYNC_DELAY-1];
  end

  // Polarity is applied after the delay line so the stages only ever hold asserted-high flags.
  assign hsync       = flg_out[1] ? HSYNC_POL : ~HSYNC_POL;
  assign vsync       = flg_out[2] ? VSYNC_POL : ~VSYNC_POL;
  assign active      = flg_out[0];
  assign x           = x_q;
  assign y           = y_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_hdmi_video_timing.sv
// Bench for hdmi_video_timing: default, SYNC_DELAY=3 and a tiny positive-polarity raster run
// side by side against a cycle model, with a scoreboard queue for the delayed flags.
module tb_hdmi_video_timing;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       hs;
    logic       vs;
    logic       act;
    logic       ls;
    logic       fs;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [9:0] a_x, a_y, b_x, b_y;
  logic [2:0] c_x, c_y;
  logic a_hs, a_vs, a_act, a_ls, a_fs;
  logic b_hs, b_vs, b_act, b_ls, b_fs;
  logic c_hs, c_vs, c_act, c_ls, c_fs;

  hdmi_video_timing u_a (
    .clk_pixel(clk), .resetn(rst_n), .x(a_x), .y(a_y), .hsync(a_hs), .vsync(a_vs),
    .active(a_act), .line_start(a_ls), .frame_start(a_fs)
  );

  hdmi_video_timing #(.SYNC_DELAY(3)) u_b (
    .clk_pixel(clk), .resetn(rst_n), .x(b_x), .y(b_y), .hsync(b_hs), .vsync(b_vs),
    .active(b_act), .line_start(b_ls), .frame_start(b_fs)
  );

  hdmi_video_timing #(
    .H_ACTIVE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_ACTIVE(2), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .X_WIDTH(3), .Y_WIDTH(3)
  ) u_c (
    .clk_pixel(clk), .resetn(rst_n), .x(c_x), .y(c_y), .hsync(c_hs), .vsync(c_vs),
    .active(c_act), .line_start(c_ls), .frame_start(c_fs)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int tick_n   = 0;
  int edges    = 0;
  int mxa, mya, mxc, myc;
  int e0;
  bit rec = 1'b0;
  exp_t q_b[$];

  // Edge bookkeeping for the measurement checks.
  logic a_hs_prev = 1'b1, b_hs_prev = 1'b1, b_act_prev = 1'b0;
  int a_fall[$], a_fall_x[$], a_rise[$], b_fall[$], b_act_rise[$];
  int c_fs_t[$], c_vs_frm[$], c_act_frm[$];
  int c_vs_cnt = 0, c_act_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input int x, input int y, input int ha, input int hf,
                                 input int hw, input int va, input int vf, input int vw,
                                 input bit hp, input bit vp);
    exp_t e;
    e.x   = 10'(x);
    e.y   = 10'(y);
    e.act = (x < ha) && (y < va);
    e.hs  = ((x >= ha + hf) && (x < ha + hf + hw)) ? hp : ~hp;
    e.vs  = ((y >= va + vf) && (y < va + vf + vw)) ? vp : ~vp;
    e.ls  = (x == 0);
    e.fs  = (x == 0) && (y == 0);
    return e;
  endfunction

  function automatic exp_t model_a(input int x, input int y);
    return model(x, y, 640, 16, 96, 480, 10, 2, 1'b0, 1'b0);
  endfunction

  function automatic exp_t model_c(input int x, input int y);
    return model(x, y, 4, 1, 2, 2, 1, 1, 1'b1, 1'b1);
  endfunction

  function automatic exp_t pack(input logic [9:0] x, input logic [9:0] y, input logic hs,
                                input logic vs, input logic act, input logic ls, input logic fs);
    exp_t e;
    e.x = x; e.y = y; e.hs = hs; e.vs = vs; e.act = act; e.ls = ls; e.fs = fs;
    return e;
  endfunction

  task automatic reset_models();
    mxa = 799; mya = 524; mxc = 7; myc = 4; edges = 0;
    q_b.delete();
    repeat (3) q_b.push_back(model_a(799, 524));
  endtask

  // One pixel clock: advance the model at the edge, queue expectations, compare at negedge.
  task automatic tick();
    exp_t ea, ec, eb, ob;
    @(posedge clk);
    tick_n++;
    if (rst_n) edges++;
    if (rst_n && edges >= 2) begin
      if (mxa == 799) begin mxa = 0; mya = (mya == 524) ? 0 : mya + 1; end
      else mxa++;
      if (mxc == 7) begin mxc = 0; myc = (myc == 4) ? 0 : myc + 1; end
      else mxc++;
    end
    ea = model_a(mxa, mya);
    ec = model_c(mxc, myc);
    q_b.push_back(ea);
    @(negedge clk);
    chk($sformatf("a t%0d", tick_n), 32'(pack(a_x, a_y, a_hs, a_vs, a_act, a_ls, a_fs)),
        32'(ea));
    eb = q_b.pop_front();
    ob = pack(ea.x, ea.y, eb.hs, eb.vs, eb.act, ea.ls, ea.fs);
    chk($sformatf("b t%0d", tick_n), 32'(pack(b_x, b_y, b_hs, b_vs, b_act, b_ls, b_fs)),
        32'(ob));
    chk($sformatf("c t%0d", tick_n),
        32'(pack(10'(c_x), 10'(c_y), c_hs, c_vs, c_act, c_ls, c_fs)), 32'(ec));
    if (rec) begin
      if (a_hs_prev && !a_hs) begin a_fall.push_back(tick_n); a_fall_x.push_back(int'(a_x)); end
      if (!a_hs_prev && a_hs) a_rise.push_back(tick_n);
      if (b_hs_prev && !b_hs) b_fall.push_back(tick_n);
      if (!b_act_prev && b_act) b_act_rise.push_back(tick_n);
      if (c_fs) begin
        c_fs_t.push_back(tick_n);
        c_vs_frm.push_back(c_vs_cnt);
        c_act_frm.push_back(c_act_cnt);
        c_vs_cnt = 0;
        c_act_cnt = 0;
      end
      if (c_vs) c_vs_cnt++;
      if (c_act) c_act_cnt++;
    end
    a_hs_prev  = a_hs;
    b_hs_prev  = b_hs;
    b_act_prev = b_act;
  endtask

  initial begin
    reset_models();
    repeat (5) tick();
    chk("rst a_x", 32'(a_x), 32'd799);
    chk("rst a_y", 32'(a_y), 32'd524);
    chk("rst c idle hsync", 32'(c_hs), 32'd0);
    chk("rst c idle vsync", 32'(c_vs), 32'd0);

    rst_n = 1'b1;
    rec   = 1'b1;
    tick();
    chk("edge1 a_x held", 32'(a_x), 32'd799);
    tick();
    e0 = tick_n;
    chk("E0 a_x", 32'(a_x), 32'd0);
    chk("E0 a_y", 32'(a_y), 32'd0);
    chk("E0 a_active", 32'(a_act), 32'd1);
    chk("E0 a_frame_start", 32'(a_fs), 32'd1);
    chk("E0 b_frame_start", 32'(b_fs), 32'd1);
    chk("E0 b_active lags", 32'(b_act), 32'd0);
    repeat (640) tick();
    chk("E0+640 a_x", 32'(a_x), 32'd640);
    chk("E0+640 a_active", 32'(a_act), 32'd0);

    for (int i = 0; i < 2000 && !(a_y == 10'd2 && a_x == 10'd300); i++) tick();
    chk("reached x300 y2", 32'(a_y == 10'd2 && a_x == 10'd300), 32'd1);

    chk("a hsync falls seen", 32'(a_fall.size() >= 2 && a_rise.size() >= 1), 32'd1);
    if (a_fall.size() >= 2 && a_rise.size() >= 1) begin
      chk("a hsync period", 32'(a_fall[1] - a_fall[0]), 32'd800);
      chk("a hsync low width", 32'(a_rise[0] - a_fall[0]), 32'd96);
      chk("a hsync fall x", 32'(a_fall_x[0]), 32'd656);
    end
    chk("b edges seen", 32'(b_fall.size() >= 1 && b_act_rise.size() >= 1), 32'd1);
    if (b_fall.size() >= 1 && b_act_rise.size() >= 1 && a_fall.size() >= 1) begin
      chk("b active rise lag", 32'(b_act_rise[0] - e0), 32'd3);
      chk("b hsync fall lag", 32'(b_fall[0] - a_fall[0]), 32'd3);
    end
    chk("c frames seen", 32'(c_fs_t.size() >= 3), 32'd1);
    if (c_fs_t.size() >= 3) begin
      chk("c frame period", 32'(c_fs_t[1] - c_fs_t[0]), 32'd40);
      chk("c vsync cycles/frame", 32'(c_vs_frm[1]), 32'd8);
      chk("c active cycles/frame", 32'(c_act_frm[1]), 32'd8);
    end

    // Asynchronous reset between clock edges.
    #2 rst_n = 1'b0;
    #1;
    chk("midrst a_x", 32'(a_x), 32'd799);
    chk("midrst a_y", 32'(a_y), 32'd524);
    chk("midrst a_active", 32'(a_act), 32'd0);
    chk("midrst a_hsync", 32'(a_hs), 32'd1);
    chk("midrst a_vsync", 32'(a_vs), 32'd1);
    chk("midrst b_active", 32'(b_act), 32'd0);
    chk("midrst c_hsync", 32'(c_hs), 32'd0);
    rec = 1'b0;
    reset_models();
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    tick();
    chk("restart a_x", 32'(a_x), 32'd0);
    chk("restart a_y", 32'(a_y), 32'd0);
    chk("restart a_frame_start", 32'(a_fs), 32'd1);
    repeat (20) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
